// File: rtl/mna_noc_pkg.sv
// Shared NoC flit definitions for the master network adapter and flit builders.
package mna_noc_pkg;

    localparam int FLIT_W    = 37;
    localparam int DATA_W    = 32;
    localparam int VC_W      = 3;
    localparam int NODE_W    = 4;
    localparam int ERR_CNT_W = 8;

    // Field bit positions inside a flit
    localparam int TYPE_MSB = 36;
    localparam int TYPE_LSB = 35;
    localparam int VC_MSB   = 34;
    localparam int VC_LSB   = 32;
    localparam int SRC_MSB  = 31;
    localparam int SRC_LSB  = 28;
    localparam int KIND_BIT = 0;

    typedef enum logic [1:0] {
        FLIT_BODY    = 2'b00,
        FLIT_TAIL    = 2'b01,
        FLIT_HEADER  = 2'b10,
        FLIT_ILLEGAL = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TAIL = 2'd1,
        ST_R_OUT     = 2'd2,
        ST_B_OUT     = 2'd3
    } rx_state_e;

endpackage

// File: rtl/mna_flit_field_decode.sv
// Pure combinational split of a NoC flit into its fields.
module mna_flit_field_decode
    import mna_noc_pkg::*;
(
    input  logic [FLIT_W-1:0] flit_i,
    output flit_type_e        type_o,
    output logic [VC_W-1:0]   vc_o,
    output logic [NODE_W-1:0] src_o,
    output logic              kind_o,
    output logic [DATA_W-1:0] payload_o
);

    assign type_o    = flit_type_e'(flit_i[TYPE_MSB:TYPE_LSB]);
    assign vc_o      = flit_i[VC_MSB:VC_LSB];
    assign src_o     = flit_i[SRC_MSB:SRC_LSB];
    assign kind_o    = flit_i[KIND_BIT];
    assign payload_o = flit_i[DATA_W-1:0];

endmodule

// File: rtl/mna_resp_flit_receiver.sv
// MNA response receiver: reassembles header/tail response packets from the NoC
// and presents them as one AXI4-Lite R or B beat, flagging protocol errors.
module mna_resp_flit_receiver
    import mna_noc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [FLIT_W-1:0]    flit_in,
    input  logic                 flit_valid,
    output logic                 flit_ready,
    output logic [DATA_W-1:0]    rdata,
    output logic [1:0]           rresp,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [1:0]           bresp,
    output logic                 bvalid,
    input  logic                 bready,
    output logic [NODE_W-1:0]    resp_src,
    output logic [VC_W-1:0]      resp_vc,
    output logic                 proto_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    rx_state_e             state_q, state_d;
    logic [NODE_W-1:0]     src_q, src_d;
    logic [VC_W-1:0]       vc_q, vc_d;
    logic                  kind_q, kind_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  perr_q, perr_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

    flit_type_e            f_type;
    logic [VC_W-1:0]       f_vc;
    logic [NODE_W-1:0]     f_src;
    logic                  f_kind;
    logic [DATA_W-1:0]     f_payload;
    logic                  accept;

    mna_flit_field_decode u_decode (
        .flit_i    (flit_in),
        .type_o    (f_type),
        .vc_o      (f_vc),
        .src_o     (f_src),
        .kind_o    (f_kind),
        .payload_o (f_payload)
    );

    // Ready is a pure state decode so the NoC never sees a combinational path
    assign flit_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT_TAIL);
    assign accept     = flit_valid && flit_ready;

    // Next-state and field-capture logic of the packet FSM
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        vc_d    = vc_q;
        kind_d  = kind_q;
        rdata_d = rdata_q;
        bresp_d = bresp_q;
        perr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (f_type == FLIT_HEADER) begin
                        src_d   = f_src;
                        vc_d    = f_vc;
                        kind_d  = f_kind;
                        state_d = ST_WAIT_TAIL;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            ST_WAIT_TAIL: begin
                if (accept) begin
                    case (f_type)
                        // A header mid-packet abandons the old packet and restarts
                        FLIT_HEADER: begin
                            perr_d = 1'b1;
                            src_d  = f_src;
                            vc_d   = f_vc;
                            kind_d = f_kind;
                        end
                        FLIT_BODY: begin
                            if (f_vc != vc_q) perr_d = 1'b1;
                        end
                        FLIT_TAIL: begin
                            if (f_vc != vc_q) begin
                                perr_d = 1'b1;
                            end else if (kind_q) begin
                                rdata_d = f_payload;
                                state_d = ST_R_OUT;
                            end else begin
                                bresp_d = f_payload[1:0];
                                state_d = ST_B_OUT;
                            end
                        end
                        default: perr_d = 1'b1;
                    endcase
                end
            end
            ST_R_OUT: if (rready) state_d = ST_IDLE;
            ST_B_OUT: if (bready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Saturating protocol-error counter
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (perr_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    // State and captured-field registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            vc_q      <= '0;
            kind_q    <= 1'b0;
            rdata_q   <= '0;
            bresp_q   <= '0;
            perr_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            vc_q      <= vc_d;
            kind_q    <= kind_d;
            rdata_q   <= rdata_d;
            bresp_q   <= bresp_d;
            perr_q    <= perr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rvalid    = (state_q == ST_R_OUT);
    assign bvalid    = (state_q == ST_B_OUT);
    assign rdata     = rdata_q;
    assign rresp     = 2'b00;
    assign bresp     = bresp_q;
    assign resp_src  = src_q;
    assign resp_vc   = vc_q;
    assign proto_err = perr_q;
    assign err_count = err_cnt_q;

endmodule
